// File: rtl/ntt_agu_if.sv
// Command/address bundle between an NTT controller and the address generation unit.
interface ntt_agu_if #(
   parameter int LOGN = 8
);
   localparam int SW = $clog2(LOGN);

   logic            start;
   logic            mode;
   logic            hold;
   logic            rd_en;
   logic [LOGN-1:0] rd_addr_a;
   logic [LOGN-1:0] rd_addr_b;
   logic            rd_bank;
   logic [LOGN-1:0] tw_addr;
   logic            bfu_en;
   logic            wr_en;
   logic [LOGN-1:0] wr_addr_a;
   logic [LOGN-1:0] wr_addr_b;
   logic            wr_bank;
   logic [SW-1:0]   stage;
   logic            busy;
   logic            done;

   modport master (
      output start, mode, hold,
      input  rd_en, rd_addr_a, rd_addr_b, rd_bank, tw_addr, bfu_en,
             wr_en, wr_addr_a, wr_addr_b, wr_bank, stage, busy, done
   );

   modport slave (
      input  start, mode, hold,
      output rd_en, rd_addr_a, rd_addr_b, rd_bank, tw_addr, bfu_en,
             wr_en, wr_addr_a, wr_addr_b, wr_bank, stage, busy, done
   );
endinterface

// File: rtl/ntt_agu.sv
// In-place radix-2 NTT/INTT address generator: butterfly operand, twiddle and
// ping-pong write-back addressing with a BFU_LAT+1 deep write-back delay line.
module ntt_agu #(
   parameter int LOGN    = 8,
   parameter int BFU_LAT = 4
) (
   input logic      clk,
   input logic      reset,
   ntt_agu_if.slave bus
);
   localparam int SW = $clog2(LOGN);
   localparam int DL = BFU_LAT + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic            vld;
      logic [LOGN-1:0] a;
      logic [LOGN-1:0] b;
      logic            bank;
   } wb_t;

   state_t          state;
   state_t          state_nx;
   logic            mode_l;
   logic [SW-1:0]   stage;
   logic [LOGN-2:0] bcnt;
   logic [4:0]      cnt;
   wb_t             line_p [DL];

   logic            issue;
   logic            last_b;
   logic            drain_end;
   logic            last_stage;
   logic [SW-1:0]   hs;
   logic [SW-1:0]   ts;
   logic [LOGN-1:0] bx;
   logic [LOGN-1:0] g;
   logic [LOGN-1:0] o;
   logic [LOGN-1:0] a;
   logic [LOGN-1:0] b_addr;
   logic [LOGN-1:0] tw;

   assign issue      = reset && (state == RUN) && !bus.hold;
   assign last_b     = (bcnt == '1);
   assign drain_end  = (cnt == 5'(BFU_LAT));
   assign last_stage = (stage == SW'(LOGN-1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (issue && last_b) state_nx = DRAIN;
         DRAIN:   if (drain_end) state_nx = last_stage ? DONE : RUN;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // hs = log2(half); group g and offset o split b, operand a re-inserts a zero at bit hs
   always_comb begin
      hs     = mode_l ? stage : SW'(LOGN-1) - stage;
      ts     = mode_l ? SW'(LOGN-1) - stage : stage;
      bx     = {1'b0, bcnt};
      g      = bx >> hs;
      o      = bx & ((LOGN'(1) << hs) - LOGN'(1));
      a      = ((g << hs) << 1) | o;
      b_addr = a | (LOGN'(1) << hs);
      tw     = (LOGN'(1) << ts) + g;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         mode_l <= 1'b0;
         stage  <= '0;
         bcnt   <= '0;
         cnt    <= '0;
         for (int i = 0; i < DL; i++) line_p[i] <= '0;
      end else begin
         state     <= state_nx;
         // hold bubbles enter the line as empty slots so write gaps mirror read gaps
         line_p[0] <= issue ? wb_t'{1'b1, a, b_addr, ~stage[0]} : '0;
         for (int i = 1; i < DL; i++) line_p[i] <= line_p[i-1];
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mode_l <= bus.mode;
                  stage  <= '0;
                  bcnt   <= '0;
               end
            end
            RUN: begin
               cnt <= '0;
               if (issue) bcnt <= bcnt + (LOGN-1)'(1);
            end
            DRAIN: begin
               cnt <= cnt + 5'd1;
               if (drain_end && !last_stage) begin
                  stage <= stage + SW'(1);
                  bcnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rd_en     = issue;
   assign bus.rd_addr_a = issue ? a : '0;
   assign bus.rd_addr_b = issue ? b_addr : '0;
   assign bus.tw_addr   = issue ? tw : '0;
   assign bus.rd_bank   = reset & stage[0];
   assign bus.bfu_en    = reset & line_p[0].vld;
   assign bus.wr_en     = reset & line_p[DL-1].vld;
   assign bus.wr_addr_a = reset ? line_p[DL-1].a : '0;
   assign bus.wr_addr_b = reset ? line_p[DL-1].b : '0;
   assign bus.wr_bank   = reset & line_p[DL-1].bank;
   assign bus.stage     = reset ? stage : '0;
   assign bus.busy      = reset && (state != IDLE);
   assign bus.done      = reset && (state == DONE);
endmodule

// File: tb/tb_ntt_agu.sv
// Directed bench for ntt_agu (N=8, 4-cycle butterfly): issue order, write-back
// scoreboard, hold bubbles, ignored starts and mid-transform reset.
module tb_ntt_agu;
   localparam int LOGN    = 3;
   localparam int BFU_LAT = 4;
   localparam int NN      = 1 << LOGN;

   typedef struct {
      int cyc;
      int s;
      int a;
      int b;
      int tw;
   } issue_t;

   typedef struct {
      int due;
      int a;
      int b;
      int bank;
   } wr_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   logic [31:0] obs_a  [0:63];
   logic [31:0] obs_b  [0:63];
   logic [31:0] obs_tw [0:63];
   logic [31:0] obs_st [0:63];

   ntt_agu_if #(.LOGN(LOGN)) bus ();

   ntt_agu #(.LOGN(LOGN), .BFU_LAT(BFU_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
      chk({tag, "_bfu_en"}, 32'(bus.bfu_en), 32'd0);
      chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
   endtask

   // Runs one transform starting with start=1 at relative cycle 0.
   task automatic transform(input logic m, input int hold_at, input int hold_len,
                            input int done_rel, input int rst_at, input bit spurious);
      issue_t iss[$];
      wr_t    sb[$];
      issue_t e;
      wr_t    w;
      int     t;
      int     half;
      int     span;
      logic   prev_rd;
      logic   exp_rd;
      logic   exp_wr;

      t = 1;
      for (int s = 0; s < LOGN; s++) begin
         half = m ? (1 << s) : (NN >> (s + 1));
         span = 2 * half;
         for (int gi = 0; gi < NN / span; gi++) begin
            for (int oi = 0; oi < half; oi++) begin
               while (hold_at >= 0 && t >= hold_at && t < hold_at + hold_len) t++;
               e.cyc = t;
               e.s   = s;
               e.a   = gi * span + oi;
               e.b   = e.a + half;
               e.tw  = (m ? (NN >> (s + 1)) : (1 << s)) + gi;
               iss.push_back(e);
               t++;
            end
         end
         t += BFU_LAT + 1;
      end

      prev_rd = 1'b0;
      for (int r = 0; r <= done_rel + 3; r++) begin
         if (rst_at >= 0 && r > rst_at + 4) break;
         bus.start = (r == 0) || (spurious && (r == 5 || r == 28));
         bus.mode  = (r == 0) ? m : ~m;
         bus.hold  = (hold_at >= 0 && r >= hold_at && r < hold_at + hold_len);
         reset     = !(rst_at >= 0 && r == rst_at);
         #1;
         if (rst_at >= 0 && r >= rst_at) begin
            chk_quiet("rst");
            if (r == rst_at) begin
               chk("rst_rd_addr_a", 32'(bus.rd_addr_a), 32'd0);
               chk("rst_rd_addr_b", 32'(bus.rd_addr_b), 32'd0);
               chk("rst_tw_addr", 32'(bus.tw_addr), 32'd0);
               chk("rst_wr_addr_a", 32'(bus.wr_addr_a), 32'd0);
               chk("rst_wr_addr_b", 32'(bus.wr_addr_b), 32'd0);
               chk("rst_wr_bank", 32'(bus.wr_bank), 32'd0);
               chk("rst_stage", 32'(bus.stage), 32'd0);
               chk("rst_rd_bank", 32'(bus.rd_bank), 32'd0);
            end
         end else begin
            obs_a[r]  = 32'(bus.rd_addr_a);
            obs_b[r]  = 32'(bus.rd_addr_b);
            obs_tw[r] = 32'(bus.tw_addr);
            obs_st[r] = 32'(bus.stage);
            exp_rd = (iss.size() > 0) && (iss[0].cyc == r);
            chk("rd_en", 32'(bus.rd_en), 32'(exp_rd));
            if (exp_rd) begin
               e = iss.pop_front();
               chk("rd_addr_a", 32'(bus.rd_addr_a), e.a);
               chk("rd_addr_b", 32'(bus.rd_addr_b), e.b);
               chk("tw_addr", 32'(bus.tw_addr), e.tw);
               chk("stage", 32'(bus.stage), e.s);
               chk("rd_bank", 32'(bus.rd_bank), e.s & 1);
               w.due  = r + BFU_LAT + 1;
               w.a    = e.a;
               w.b    = e.b;
               w.bank = 1 - (e.s & 1);
               sb.push_back(w);
            end
            chk("bfu_en", 32'(bus.bfu_en), 32'(prev_rd));
            prev_rd = exp_rd;
            exp_wr = (sb.size() > 0) && (sb[0].due == r);
            chk("wr_en", 32'(bus.wr_en), 32'(exp_wr));
            if (exp_wr) begin
               w = sb.pop_front();
               chk("wr_addr_a", 32'(bus.wr_addr_a), w.a);
               chk("wr_addr_b", 32'(bus.wr_addr_b), w.b);
               chk("wr_bank", 32'(bus.wr_bank), w.bank);
            end
            chk("busy", 32'(bus.busy), 32'(r >= 1 && r <= done_rel));
            chk("done", 32'(bus.done), 32'(r == done_rel));
         end
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      reset     = 1'b1;
      if (rst_at < 0) begin
         chk("issues_left", iss.size(), 32'd0);
         chk("writes_left", sb.size(), 32'd0);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      bus.start   = 1'b1;
      bus.mode    = 1'b0;
      bus.hold    = 1'b0;

      // reset wins over a simultaneous start
      repeat (3) begin
         @(posedge clk);
         #1;
         chk_quiet("reset");
         chk("reset_rd_addr_b", 32'(bus.rd_addr_b), 32'd0);
         chk("reset_tw_addr", 32'(bus.tw_addr), 32'd0);
         chk("reset_stage", 32'(bus.stage), 32'd0);
      end
      reset     = 1'b1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk_quiet("post_reset");

      transform(1'b0, -1, 0, 28, -1, 1'b0);
      chk("ntt_c1_a", obs_a[1], 32'd0);
      chk("ntt_c1_b", obs_b[1], 32'd4);
      chk("ntt_c1_tw", obs_tw[1], 32'd1);
      chk("ntt_c22_stage", obs_st[22], 32'd2);
      chk("ntt_c22_a", obs_a[22], 32'd6);
      chk("ntt_c22_b", obs_b[22], 32'd7);
      chk("ntt_c22_tw", obs_tw[22], 32'd7);

      transform(1'b1, -1, 0, 28, -1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("intt_s0_a", obs_a[1 + k], 32'(2 * k));
         chk("intt_s0_b", obs_b[1 + k], 32'(2 * k + 1));
         chk("intt_s0_tw", obs_tw[1 + k], 32'(4 + k));
      end
      chk("intt_s2_stage", obs_st[19], 32'd2);
      chk("intt_s2_a", obs_a[19], 32'd0);
      chk("intt_s2_b", obs_b[19], 32'd4);
      chk("intt_s2_tw", obs_tw[19], 32'd1);

      transform(1'b0, 11, 3, 31, -1, 1'b0);
      transform(1'b0, -1, 0, 28, -1, 1'b1);
      transform(1'b0, -1, 0, 28, 10, 1'b0);
      transform(1'b1, -1, 0, 28, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ntt_agu.md
NTT_AGU -- requirements
Module: ntt_agu

Interface
REQ-001 The block SHALL have the parameter LOGN, default 8, meaning log2 of the ring size N; legal range 3..12.
REQ-002 The block SHALL have the parameter BFU_LAT, default 4, meaning the butterfly pipeline latency in cycles; legal range 1..16.
REQ-003 The block SHALL have the port clk, input, width 1, meaning the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have the port reset, input, width 1: synchronous, active-low reset.
REQ-005 The block SHALL have the port start, input, width 1, meaning a transform request; it is sampled only in IDLE.
REQ-006 The block SHALL have the port mode, input, width 1: 0 = NTT, 1 = INTT; it is sampled together with an accepted start.
REQ-007 The block SHALL have the port hold, input, width 1: while high, the block issues no new butterflies.
REQ-008 The block SHALL have the port rd_en, output, width 1, meaning the read strobe for both bank ports.
REQ-009 The block SHALL have the ports rd_addr_a and rd_addr_b, outputs, width LOGN, meaning the butterfly operand addresses.
REQ-010 The block SHALL have the port rd_bank, output, width 1, meaning the ping-pong bank being read.
REQ-011 The block SHALL have the port tw_addr, output, width LOGN, meaning the twiddle ROM index, aligned with rd_en.
REQ-012 The block SHALL have the port bfu_en, output, width 1, equal to rd_en delayed by 1 cycle (RAM read latency).
REQ-013 The block SHALL have the ports wr_en, wr_addr_a, wr_addr_b and wr_bank, outputs, widths 1/LOGN/LOGN/1, meaning the write-back strobe, addresses and bank.
REQ-014 The block SHALL have the port stage, output, width ceil(log2(LOGN)), meaning the current stage index.
REQ-015 The block SHALL have the ports busy and done, outputs, width 1 each: busy = not IDLE; done = one-cycle completion pulse.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE, start=1 SHALL latch mode, clear the stage and butterfly counter b, and enter RUN on the next edge.
REQ-018 A start received while not in IDLE SHALL be ignored.
REQ-019 In RUN with hold=0, each cycle SHALL issue butterfly b (0..N/2-1) with rd_en=1, then increment b.
REQ-020 In RUN with hold=1, rd_en SHALL be 0 and b and stage SHALL freeze, while the delay line keeps shifting.
REQ-021 Span SHALL be half = 2^(LOGN-1-stage) for NTT and half = 2^stage for INTT.
REQ-022 With g = b / half and o = b % half, the block SHALL set rd_addr_a = 2*g*half + o and rd_addr_b = rd_addr_a + half.
REQ-023 tw_addr SHALL be 2^stage + g for NTT and 2^(LOGN-1-stage) + g for INTT; the result always fits in LOGN bits.
REQ-024 rd_bank SHALL equal stage[0], and writes SHALL go to bank ~stage[0].
REQ-025 wr_en, wr_addr_a, wr_addr_b and wr_bank SHALL equal rd_en, rd_addr_a, rd_addr_b and the issued bank inverse, delayed exactly BFU_LAT+1 cycles, with hold bubbles preserved.
REQ-026 After the issue with b = N/2-1, the FSM SHALL enter DRAIN, which lasts exactly BFU_LAT+1 cycles regardless of hold.
REQ-027 At the end of DRAIN, if stage < LOGN-1 the block SHALL increment stage, clear b and return to RUN; otherwise it SHALL enter DONE.
REQ-028 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-029 A start present during the DONE cycle SHALL be ignored.
REQ-030 Result data SHALL reside in bank LOGN[0] after done.
REQ-031 No read of stage s+1 SHALL occur before the last write of stage s has been issued.
REQ-032 In IDLE, rd_en, bfu_en and wr_en SHALL be 0 once the delay line is empty.

Reset
REQ-033 reset=0 at a clock edge SHALL force IDLE and clear stage, b and the whole delay line.
REQ-034 During reset, all outputs SHALL be 0.
REQ-035 A reset asserted mid-transform SHALL suppress every pending write, so wr_en=0 from the next cycle on.
REQ-036 Reset SHALL take priority over start.

Verification
REQ-037 Scenario: LOGN=3, BFU_LAT=4, mode=0, start at cycle 0, hold=0 -> first issue at cycle 1 is a=0, b=4, tw=1; cycle 22 is stage 2, a=6, b=7, tw=7; done=1 at cycle 28 only.
REQ-038 Scenario: LOGN=3, mode=1 -> stage 0 issues are (0,1), (2,3), (4,5), (6,7) with tw=4,5,6,7; stage 2 first issue is (0,4) with tw=1.
REQ-039 Scenario: every rd_en pulse with address pair P -> wr_en with the same P exactly 5 cycles later, with wr_bank = ~rd_bank.
REQ-040 Scenario: hold=1 for 3 cycles mid stage 1 -> issue sequence is unchanged, done is delayed by exactly 3 cycles, and the write gaps mirror the read gaps.
REQ-041 Scenario: reset=0 at cycle 10, then start at cycle 15 -> no wr_en from cycle 11 to 15, and a clean full transform follows.
REQ-042 Scenario: start pulses at cycles 5 and 28 during a run -> both are ignored, and busy stays high until done.
